sound_effect_sequencer: RTL and testbench
=========================================

SOUND_EFFECT_SEQUENCER -- requirements
Module: sound_effect_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 2500000: clock cycles per tick, 50 ms at 50 MHz; legal range >=2.
REQ-002 Parameter NOTE_TICKS, default 2: ticks per note; legal range >=1.
REQ-003 Clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 HitPaddle  input  1  single-cycle event pulse: ball struck a paddle.
REQ-006 HitWall  input  1  single-cycle event pulse: ball struck top/bottom wall.
REQ-007 Score  input  1  single-cycle event pulse: point scored.
REQ-008 Mute  input  1  level; 1 silences the key outputs.
REQ-009 keyC  output  1  level key request for note C; feeds the three-note tone generator.
REQ-010 keyD  output  1  level key request for note D.
REQ-011 keyE  output  1  level key request for note E.
REQ-012 Busy  output  1  high while a pattern is playing.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and PLAY.
REQ-014 Patterns: PADDLE = {D}, WALL = {E}, SCORE = {C, D, E}, with notes played in listed order.
REQ-015 Event priority, highest first: Score, HitPaddle, HitWall.
- When events are simultaneous, only the highest-priority event is accepted.
REQ-016 When an event is sampled in IDLE, the block SHALL enter PLAY on that edge.
- In the following cycle, Busy = 1 and the first note's key = 1 (latency 1).
REQ-017 Tick prescaler: counts 0..TICK_CYCLES-1 in PLAY; cleared on every pattern start.
- Note tick counter: counts 0..NOTE_TICKS-1; cleared on every pattern start.
REQ-018 Each note key SHALL be high for exactly NOTE_TICKS*TICK_CYCLES consecutive cycles.
REQ-019 Successive notes in a pattern SHALL be back-to-back, with no silent cycle between them.
REQ-020 At most one of keyC/keyD/keyE SHALL be high in any cycle (one-hot or all zero).
REQ-021 At the final count of the last note:
- The FSM returns to IDLE.
- In the next cycle, all keys = 0 and Busy = 0.
- No extra gap or hold cycle is inserted.
REQ-022 Preemption: an event of strictly higher priority than the playing pattern, sampled in PLAY, SHALL restart playback with the new pattern.
- The step index, prescaler and note tick counter are cleared.
- The new pattern's first key is high in the next cycle.
REQ-023 An event of equal or lower priority sampled in PLAY SHALL be ignored and SHALL NOT be queued.
REQ-024 An event arriving on the same edge that the last note completes SHALL be treated as an IDLE-state event.
- It starts its pattern with no all-zero cycle in between.
REQ-025 Mute = 1 forces keyC/keyD/keyE to 0 combinationally.
- Mute does not affect sequencing, timing or Busy.
REQ-026 Events in IDLE while Mute = 1 SHALL still start patterns, with Busy behaving normally.
REQ-027 Counters SHALL be sized from the parameters with no overflow: ceil(log2(N)) bits, minimum 1.
REQ-028 Event inputs are treated as synchronous to Clock; multi-cycle pulses simply re-trigger per REQ-016/022/023.

Reset
REQ-029 While Reset = 0, the following SHALL be held:
- The FSM is in IDLE.
- All counters and the step index are 0.
- keyC = keyD = keyE = 0 and Busy = 0.
REQ-030 Asserting Reset mid-pattern SHALL immediately force all outputs to 0, regardless of Clock.
- After Reset returns high, no pattern resumes.
- Events are honoured from the first rising edge after Reset = 1.

Verification (TICK_CYCLES=4, NOTE_TICKS=2, i.e. 8 cycles per note)
REQ-031 Paddle: HitPaddle pulse at edge N -> keyD = 1 and Busy = 1 for cycles N+1..N+8; all outputs 0 from cycle N+9.
REQ-032 Score: Score pulse at edge N -> keyC on cycles N+1..N+8, keyD on N+9..N+16, keyE on N+17..N+24; Busy = 0 at N+25.
REQ-033 Priority/preempt, two directed cases:
- HitWall and Score on the same edge -> the C,D,E sequence plays.
- HitWall at edge N, then HitPaddle at edge N+3 -> keyE on N+1..N+3, keyD on N+4..N+11.
REQ-034 Ignore: Score at edge N, then HitPaddle at edge N+5 -> the Score pattern plays unchanged, ending after N+24.
REQ-035 Mute and reset:
- Mute = 1 during a Score pattern -> keys = 0 throughout, while Busy matches REQ-032 timing.
- Reset = 0 asserted at cycle N+10 -> outputs are 0 immediately.
- After release, outputs stay idle until the next event.
REQ-036 Every test SHALL check the REQ-020 one-hot/zero invariant on every cycle.

Source files
------------

// File: rtl/sound_effect_sequencer.sv
// Plays short three-note key patterns in response to Pong game events.
// Higher-priority events preempt; equal or lower priority events are dropped while playing.
module sound_effect_sequencer #(
  parameter int TICK_CYCLES = 2500000,
  parameter int NOTE_TICKS  = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic HitPaddle,
  input  logic HitWall,
  input  logic Score,
  input  logic Mute,
  output logic keyC,
  output logic keyD,
  output logic keyE,
  output logic Busy
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int NW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [NW-1:0] TICK_LAST  = NW'(NOTE_TICKS - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_e;

  // Encoding doubles as priority, so preemption is a plain magnitude compare.
  typedef enum logic [1:0] {
    PAT_NONE   = 2'd0,
    PAT_WALL   = 2'd1,
    PAT_PADDLE = 2'd2,
    PAT_SCORE  = 2'd3
  } pat_e;

  state_e          state_q;
  pat_e            pat_q;
  logic [1:0]      step_q;
  logic [PW-1:0]   presc_q;
  logic [NW-1:0]   tick_q;
  logic [2:0]      keys_q;
  logic            busy_q;

  pat_e            evt_pat_d;
  logic            note_end_d;
  logic            last_note_d;
  logic            start_d;

  // Key vector is {E, D, C}.
  function automatic logic [2:0] noteKeys(input pat_e pat, input logic [1:0] step);
    logic [2:0] k;
    k = 3'b000;
    case (pat)
      PAT_WALL:   k = 3'b100;
      PAT_PADDLE: k = 3'b010;
      PAT_SCORE: begin
        case (step)
          2'd0:    k = 3'b001;
          2'd1:    k = 3'b010;
          default: k = 3'b100;
        endcase
      end
      default:    k = 3'b000;
    endcase
    return k;
  endfunction

  function automatic logic [1:0] lastStep(input pat_e pat);
    return (pat == PAT_SCORE) ? 2'd2 : 2'd0;
  endfunction

  always_comb begin
    evt_pat_d = PAT_NONE;
    if (Score) begin
      evt_pat_d = PAT_SCORE;
    end else if (HitPaddle) begin
      evt_pat_d = PAT_PADDLE;
    end else if (HitWall) begin
      evt_pat_d = PAT_WALL;
    end
    note_end_d  = (presc_q == PRESC_LAST) && (tick_q == TICK_LAST);
    last_note_d = (state_q == PLAY) && note_end_d && (step_q == lastStep(pat_q));
    // The edge that finishes the last note behaves like IDLE for incoming events.
    start_d     = (evt_pat_d != PAT_NONE) &&
                  ((state_q == IDLE) || last_note_d || (evt_pat_d > pat_q));
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      pat_q   <= PAT_NONE;
      step_q  <= 2'd0;
      presc_q <= '0;
      tick_q  <= '0;
      keys_q  <= 3'b000;
      busy_q  <= 1'b0;
    end else if (start_d) begin
      state_q <= PLAY;
      pat_q   <= evt_pat_d;
      step_q  <= 2'd0;
      presc_q <= '0;
      tick_q  <= '0;
      keys_q  <= noteKeys(evt_pat_d, 2'd0);
      busy_q  <= 1'b1;
    end else if (state_q == PLAY) begin
      if (last_note_d) begin
        state_q <= IDLE;
        pat_q   <= PAT_NONE;
        step_q  <= 2'd0;
        presc_q <= '0;
        tick_q  <= '0;
        keys_q  <= 3'b000;
        busy_q  <= 1'b0;
      end else if (note_end_d) begin
        step_q  <= step_q + 2'd1;
        presc_q <= '0;
        tick_q  <= '0;
        keys_q  <= noteKeys(pat_q, step_q + 2'd1);
      end else if (presc_q == PRESC_LAST) begin
        presc_q <= '0;
        tick_q  <= tick_q + 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
    end
  end

  assign keyC = keys_q[0] & ~Mute;
  assign keyD = keys_q[1] & ~Mute;
  assign keyE = keys_q[2] & ~Mute;
  assign Busy = busy_q;

endmodule

// File: tb/tb_sound_effect_sequencer.sv
// Scoreboard bench: a per-cycle note schedule model predicts {Busy,keyE,keyD,keyC};
// a negedge monitor pops predictions and compares, and checks the one-hot invariant.
module tb_sound_effect_sequencer;

  localparam int TC = 4;
  localparam int NT = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic HitPaddle = 1'b0;
  logic HitWall = 1'b0;
  logic Score = 1'b0;
  logic Mute = 1'b0;
  logic keyC, keyD, keyE, Busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] expQ[$];
  int         sched[$];
  int         curPri = 0;

  sound_effect_sequencer #(.TICK_CYCLES(TC), .NOTE_TICKS(NT)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .HitPaddle(HitPaddle),
    .HitWall(HitWall),
    .Score(Score),
    .Mute(Mute),
    .keyC(keyC),
    .keyD(keyD),
    .keyE(keyE),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  // Schedule holds one note code (0=C,1=D,2=E) per remaining playing cycle.
  task automatic modelEdge(input logic rst, input logic sc, input logic pd, input logic wl);
    int p;
    if (!rst) begin
      sched.delete();
      curPri = 0;
      return;
    end
    if (sched.size() > 0) void'(sched.pop_front());
    p = sc ? 3 : (pd ? 2 : (wl ? 1 : 0));
    if (p != 0 && (sched.size() == 0 || p > curPri)) begin
      sched.delete();
      curPri = p;
      if (p == 3) begin
        for (int n = 0; n < 3; n++)
          for (int c = 0; c < NT * TC; c++) sched.push_back(n);
      end else begin
        for (int c = 0; c < NT * TC; c++) sched.push_back(p == 2 ? 1 : 2);
      end
    end
    if (sched.size() == 0) curPri = 0;
  endtask

  function automatic logic [3:0] modelOut(input logic mute);
    logic [3:0] o;
    o = 4'b0000;
    if (sched.size() > 0) begin
      o[3] = 1'b1;
      if (!mute) o[sched[0]] = 1'b1;
    end
    return o;
  endfunction

  // One clock: the edge samples the currently driven inputs, then new inputs are applied.
  task automatic applyStimulus(input logic sc, input logic pd, input logic wl,
                               input logic mute, input logic rst);
    logic wasRst;
    @(posedge Clock);
    modelEdge(Reset, Score, HitPaddle, HitWall);
    #2;
    wasRst    = Reset;
    Score     = sc;
    HitPaddle = pd;
    HitWall   = wl;
    Mute      = mute;
    Reset     = rst;
    if (!rst) modelEdge(1'b0, 1'b0, 1'b0, 1'b0);
    expQ.push_back(modelOut(mute));
    if (wasRst && !rst) begin
      #1;
      checkOutput("reset_immediate", {Busy, keyE, keyD, keyC}, 4'b0000);
    end
  endtask

  task automatic idle(input int n, input logic mute);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, mute, 1'b1);
  endtask

  initial begin : monitor
    logic [3:0] act;
    logic [3:0] exp;
    forever begin
      @(negedge Clock);
      act = {Busy, keyE, keyD, keyC};
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkOutput("outputs", act, exp);
      end
      checkOutput("onehot", {3'b000, $countones(act[2:0]) <= 1}, 4'b0001);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    #1;
    checkOutput("reset_state", {Busy, keyE, keyD, keyC}, 4'b0000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);

    $display("[TB] paddle pattern");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(12, 1'b0);

    $display("[TB] score pattern");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(28, 1'b0);

    $display("[TB] simultaneous wall and score");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(28, 1'b0);

    $display("[TB] wall preempted by paddle");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(12, 1'b0);

    $display("[TB] paddle ignored during score");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(25, 1'b0);

    $display("[TB] back-to-back paddle at last-note edge");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(7, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(12, 1'b0);

    $display("[TB] muted score");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(28, 1'b1);
    idle(2, 1'b0);

    $display("[TB] reset mid-pattern");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(9, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(10, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      logic sc, pd, wl, mu, rs;
      sc = ($urandom_range(0, 39) == 0);
      pd = ($urandom_range(0, 19) == 0);
      wl = ($urandom_range(0, 14) == 0);
      mu = ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 299) != 0);
      applyStimulus(sc, pd, wl, mu, rs);
    end
    idle(30, 1'b0);

    repeat (2) @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
